// File: rtl/wptr_full_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO write and read controllers.
// Gray/binary conversions work on a 32-bit word; callers cast to their pointer width.
package wptr_full_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF   = 3;
    localparam int AFULL_THRESH_DEF = 6;

    // Pointers carry one extra wrap bit beyond the memory address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; upper zero bits leave narrow values intact.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter, shared with the read-side controller.
module wptr_full_ctrl_gray2bin
    import wptr_full_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = WIDTH'(gray2bin(32'(gray)));
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/level/overflow controller for the async FIFO.
// Status flags are computed from the next pointer so full asserts on the edge of the depth-th write.
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
    input  logic                  clr_ovf,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  mem_wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    // Full when the pointers differ only in the two top Gray bits.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);
    localparam logic [PTR_W-1:0] AF_T      = PTR_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
    logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;

    logic             acc;
    logic [PTR_W-1:0] rd_bin;

    wptr_full_ctrl_gray2bin #(.WIDTH(PTR_W)) u_rd_g2b (
        .gray (rd_ptr_sync),
        .bin  (rd_bin)
    );

    // Writes are refused during reset so the memory is never strobed then.
    always_comb begin
        acc       = wr_en & ~full_q & ~rst;
        wr_bin_d  = wr_bin_q + {{(PTR_W-1){1'b0}}, acc};
        wr_gray_d = PTR_W'(bin2gray(32'(wr_bin_d)));
        full_d    = (wr_gray_d == (rd_ptr_sync ^ FULL_MASK));
        level_d   = wr_bin_d - rd_bin;
        afull_d   = (level_d >= AF_T);
        ovf_d     = (wr_en & full_q) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_ptr_gray = wr_gray_q;
    assign wr_addr     = wr_bin_q[ADDR_WIDTH-1:0];
    assign mem_wr_en   = acc;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-domain pointer and full-flag controller for the async FIFO.
- Maintains the binary and Gray write pointers.
- Drives the memory write address/enable.
- Compares its Gray pointer against the read pointer delivered by the P_SYNC instance in the write domain to produce full, almost_full, fill level and a sticky overflow flag.
- Its registered Gray output feeds the P_SYNC instance that carries the write pointer into the read domain.

Parameters:
- ADDR_WIDTH, 3, FIFO address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (P_SYNC BUS_WIDTH = ADDR_WIDTH+1).
- AFULL_THRESH, 6, almost_full asserts when fill level >= this value; legal range 1..2**ADDR_WIDTH.

Ports:
- CLK  in  1  write-domain clock.
- rst  in  1  synchronous active-high reset; single clock CLK, sampled on posedge CLK.
- wr_en  in  1  write request from producer.
- rd_ptr_sync  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into CLK domain.
- clr_ovf  in  1  clears the overflow flag.
- wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer.
- wr_addr  out  ADDR_WIDTH  memory write address = wr_bin[ADDR_WIDTH-1:0].
- mem_wr_en  out  1  memory write strobe.
- full  out  1  registered full flag.
- almost_full  out  1  registered, level >= AFULL_THRESH.
- wr_level  out  ADDR_WIDTH+1  registered fill level as seen from write domain, 0..depth.
- overflow  out  1  sticky, set on write attempt while full.

Behaviour:
- Reset (rst=1 at posedge): wr_bin=0, wr_ptr_gray=0, full=0, almost_full=0, wr_level=0, overflow=0.
- Accept: acc = wr_en & ~full. mem_wr_en = acc, combinational, same cycle as wr_addr. Memory samples on the same edge.
- Next pointer: bin_nxt = wr_bin + acc, modulo 2**(ADDR_WIDTH+1), wrapping naturally. gray_nxt = bin_nxt ^ (bin_nxt >> 1).
- Registers on each edge: wr_bin <= bin_nxt; wr_ptr_gray <= gray_nxt. wr_ptr_gray never changes more than one bit per cycle.
- Full: full <= (gray_nxt == {~rd_ptr_sync[MSB:MSB-1], rd_ptr_sync[MSB-2:0]}). It asserts on the same edge that registers the depth-th outstanding write, so there is zero-latency protection.
- Level: rd_bin = Gray-to-binary of rd_ptr_sync (combinational XOR prefix). wr_level <= bin_nxt - rd_bin, modulo 2**(ADDR_WIDTH+1). It is always <= depth given legal Gray input.
- almost_full <= (bin_nxt - rd_bin) >= AFULL_THRESH.
- Pessimism: full, almost_full and wr_level lag actual reads by the synchronizer latency (NUM_STAGES cycles plus source register). This is intended. full never deasserts early.
- Overflow: set when wr_en & full. Cleared by clr_ovf. Set wins if both occur in the same cycle. The rejected write does not move the pointer.
- Simultaneous write and read-pointer advance while full=0 and level=depth-1: full stays 0, level stays depth-1.
- Reset mid-operation: all state returns to reset values on that edge. The read side must be reset concurrently, which is a system-level requirement.

Decomposition:
- Shared package: pointer width constant (ADDR_WIDTH+1), bin2gray and gray2bin functions, reused by the read-side rptr_empty_ctrl.
- One natural sub-module: gray2bin (combinational, parameterized width), shared with the read side.
- Everything else stays flat.

Test Plan:
- Reset: hold rst=1 for 2 cycles with wr_en=1 -> all outputs 0, mem_wr_en=0 after release until the first edge, no pointer motion during reset.
- Fill: rd_ptr_sync=0, 8 consecutive wr_en -> wr_ptr_gray steps 0,1,3,2,6,7,5,4,C(hex); almost_full=1 after the 6th write; full=1 and wr_level=8 after the 8th.
- Overflow: while full, wr_en=1 for 1 cycle -> mem_wr_en=0, wr_ptr_gray stays C, overflow=1. Pulse clr_ovf with wr_en=0 -> overflow=0. clr_ovf and wr_en together while full -> overflow stays 1.
- Drain release: from full, set rd_ptr_sync=1 (Gray 0001) -> next edge full=0, wr_level=7. A write then gives full=1 again, wr_ptr_gray=D.
- Wrap-around: stream 20 writes while rd_ptr_sync tracks wr_ptr_gray delayed by 2 cycles -> pointer wraps F->0 in binary (Gray 8->0). full never asserts, wr_level stays <= 3, wr_addr cycles 0..7.
- Threshold boundary: AFULL_THRESH=8 build, 7 writes -> almost_full=0; 8th write -> almost_full=1 and full=1 on the same edge.
